// File: rtl/bus_mailbox_slave_if.sv
// Bus and fabric handshake signals of the mailbox slave.
// The master modport is the bridge plus fabric side, and the slave modport is the mailbox.
interface bus_mailbox_slave_if;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_we;
  logic        bus_re;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic [31:0] dl_data;
  logic        dl_valid;
  logic        dl_ready;
  logic [31:0] ul_data;
  logic        ul_valid;
  logic        ul_ready;

  modport slave (
    input  bus_addr, bus_wdata, bus_we, bus_re, dl_ready, ul_data, ul_valid,
    output bus_rdata, bus_ack, dl_data, dl_valid, ul_ready
  );

  modport master (
    output bus_addr, bus_wdata, bus_we, bus_re, dl_ready, ul_data, ul_valid,
    input  bus_rdata, bus_ack, dl_data, dl_valid, ul_ready
  );
endinterface

// File: rtl/bus_mailbox_slave.sv
// Two-way mailbox on the bridge bus.
// The downlink FIFO is fed by host DATA writes, and the uplink FIFO is drained by host DATA reads.
module bus_mailbox_slave #(
  parameter logic [31:0] ADDRVAL    = 32'h2000_0000,
  parameter int          DEPTH_LOG2 = 4
) (
  input logic               i_clk,
  input logic               i_rstn,
  bus_mailbox_slave_if.slave bus
);
  localparam int          DEPTH  = 1 << DEPTH_LOG2;
  localparam int          CW     = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [31:0] A_DATA = ADDRVAL;
  localparam logic [31:0] A_STAT = ADDRVAL + 32'd1;
  localparam logic [31:0] A_CTRL = ADDRVAL + 32'd2;

  logic [31:0]           dl_mem [DEPTH];
  logic [31:0]           ul_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] dl_wr, dl_rd, ul_wr, ul_rd;
  logic [CW-1:0]         dl_cnt, ul_cnt, dl_cnt_nxt, ul_cnt_nxt;
  logic                  dl_ovf, ul_unf, ack_q, ul_ready_q;
  logic [31:0]           rdata_q, rd_val;

  logic hit_data_w, hit_ctrl_w, hit_data_r, hit_any_r;
  logic dl_full, dl_empty, ul_full, ul_empty;
  logic dl_push, dl_pop, ul_push, ul_pop, flush, clr;
  logic [7:0] dl_cnt8, ul_cnt8;

  always_comb begin
    hit_data_w = bus.bus_we && (bus.bus_addr == A_DATA);
    hit_ctrl_w = bus.bus_we && (bus.bus_addr == A_CTRL);
    hit_data_r = bus.bus_re && (bus.bus_addr == A_DATA);
    hit_any_r  = bus.bus_re && ((bus.bus_addr == A_DATA) || (bus.bus_addr == A_STAT) ||
                                (bus.bus_addr == A_CTRL));
    dl_full  = (dl_cnt == CNT_FULL);
    dl_empty = (dl_cnt == '0);
    ul_full  = (ul_cnt == CNT_FULL);
    ul_empty = (ul_cnt == '0);
    // Full/empty are judged on the pre-cycle state, so a same-cycle pop never frees room for a push.
    dl_push  = hit_data_w && !dl_full;
    dl_pop   = !dl_empty && bus.dl_ready;
    ul_push  = bus.ul_valid && ul_ready_q;
    ul_pop   = hit_data_r && !ul_empty;
    flush    = hit_ctrl_w && bus.bus_wdata[1];
    clr      = hit_ctrl_w && bus.bus_wdata[0];
    dl_cnt_nxt = flush ? '0 : dl_cnt + CW'(dl_push) - CW'(dl_pop);
    ul_cnt_nxt = flush ? '0 : ul_cnt + CW'(ul_push) - CW'(ul_pop);
    dl_cnt8  = 8'(dl_cnt);
    ul_cnt8  = 8'(ul_cnt);
  end

  always_comb begin
    rd_val = 32'd0;
    if (bus.bus_addr == A_DATA)
      rd_val = ul_empty ? 32'd0 : ul_mem[ul_rd];
    else if (bus.bus_addr == A_STAT)
      rd_val = {dl_ovf, ul_unf, dl_full, ul_empty, 4'd0, ul_cnt8, 8'd0, dl_cnt8};
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      dl_wr      <= '0;
      dl_rd      <= '0;
      ul_wr      <= '0;
      ul_rd      <= '0;
      dl_cnt     <= '0;
      ul_cnt     <= '0;
      dl_ovf     <= 1'b0;
      ul_unf     <= 1'b0;
      ack_q      <= 1'b0;
      rdata_q    <= 32'd0;
      ul_ready_q <= 1'b0;
    end else begin
      if (flush) begin
        dl_wr <= '0;
        dl_rd <= '0;
        ul_wr <= '0;
        ul_rd <= '0;
      end else begin
        if (dl_push) dl_wr <= dl_wr + DEPTH_LOG2'(1);
        if (dl_pop)  dl_rd <= dl_rd + DEPTH_LOG2'(1);
        if (ul_push) ul_wr <= ul_wr + DEPTH_LOG2'(1);
        if (ul_pop)  ul_rd <= ul_rd + DEPTH_LOG2'(1);
      end
      dl_cnt     <= dl_cnt_nxt;
      ul_cnt     <= ul_cnt_nxt;
      ul_ready_q <= (ul_cnt_nxt != CNT_FULL);
      // A new event in the same cycle as a clear leaves its flag set.
      dl_ovf     <= (hit_data_w && dl_full) || (dl_ovf && !clr);
      ul_unf     <= (hit_data_r && ul_empty) || (ul_unf && !clr);
      ack_q      <= hit_any_r;
      rdata_q    <= hit_any_r ? rd_val : 32'd0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (dl_push) dl_mem[dl_wr] <= bus.bus_wdata;
    if (ul_push) ul_mem[ul_wr] <= bus.ul_data;
  end

  assign bus.dl_data   = dl_empty ? 32'd0 : dl_mem[dl_rd];
  assign bus.dl_valid  = !dl_empty;
  assign bus.ul_ready  = ul_ready_q;
  assign bus.bus_ack   = ack_q;
  assign bus.bus_rdata = rdata_q;
endmodule

// File: tb/tb_bus_mailbox_slave.sv
// Directed bench for the mailbox slave.
// Inputs are driven and outputs are sampled on the falling edge of the clock.
module tb_bus_mailbox_slave;
  localparam logic [31:0] A_DATA = 32'h2000_0000;
  localparam logic [31:0] A_STAT = 32'h2000_0001;
  localparam logic [31:0] A_CTRL = 32'h2000_0002;
  localparam logic [31:0] A_BAD  = 32'h2000_0003;

  logic i_clk  = 1'b0;
  logic i_rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  bus_mailbox_slave_if bif ();

  bus_mailbox_slave #(.ADDRVAL(32'h2000_0000), .DEPTH_LOG2(4)) dut (
    .i_clk (i_clk),
    .i_rstn(i_rstn),
    .bus   (bif)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge i_clk);
    bif.bus_addr  = a;
    bif.bus_wdata = d;
    bif.bus_we    = 1'b1;
    @(negedge i_clk);
    bif.bus_we    = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    @(negedge i_clk);
    bif.bus_addr = a;
    bif.bus_re   = 1'b1;
    @(negedge i_clk);
    bif.bus_re   = 1'b0;
    chk({tag, "_ack"}, 32'(bif.bus_ack), 32'd1);
    chk(tag, bif.bus_rdata, exp);
  endtask

  initial begin
    bif.bus_addr  = 32'd0;
    bif.bus_wdata = 32'd0;
    bif.bus_we    = 1'b0;
    bif.bus_re    = 1'b0;
    bif.dl_ready  = 1'b0;
    bif.ul_data   = 32'd0;
    bif.ul_valid  = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("rst_ack", 32'(bif.bus_ack), 32'd0);
    chk("rst_rdata", bif.bus_rdata, 32'd0);
    chk("rst_dl_valid", 32'(bif.dl_valid), 32'd0);
    chk("rst_dl_data", bif.dl_data, 32'd0);
    chk("rst_ul_ready", 32'(bif.ul_ready), 32'd0);
    i_rstn = 1'b1;
    @(negedge i_clk);
    chk("ul_ready_after_rst", 32'(bif.ul_ready), 32'd1);

    // three downlink words, popped in order
    wr(A_DATA, 32'hA);
    chk("dl_valid_next", 32'(bif.dl_valid), 32'd1);
    chk("dl_head_a", bif.dl_data, 32'hA);
    chk("wr_no_ack", 32'(bif.bus_ack), 32'd0);
    wr(A_DATA, 32'hB);
    wr(A_DATA, 32'hC);
    rd(A_STAT, 32'h1000_0003, "stat_dl3");
    @(negedge i_clk);
    bif.dl_ready = 1'b1;
    chk("pop_a", bif.dl_data, 32'hA);
    @(negedge i_clk);
    chk("pop_b", bif.dl_data, 32'hB);
    @(negedge i_clk);
    chk("pop_c", bif.dl_data, 32'hC);
    @(negedge i_clk);
    bif.dl_ready = 1'b0;
    chk("dl_drained", 32'(bif.dl_valid), 32'd0);

    // fill downlink, overflow, clear
    for (int i = 0; i < 16; i++) wr(A_DATA, 32'h100 + 32'(i));
    wr(A_DATA, 32'hDEAD);
    rd(A_STAT, 32'hB000_0010, "stat_ovf_full");
    chk("dl_head_kept", bif.dl_data, 32'h100);
    wr(A_CTRL, 32'h1);
    rd(A_STAT, 32'h3000_0010, "stat_ovf_clr");

    // full downlink: same-cycle write and pop, write is dropped
    @(negedge i_clk);
    bif.bus_addr  = A_DATA;
    bif.bus_wdata = 32'hBEEF;
    bif.bus_we    = 1'b1;
    bif.dl_ready  = 1'b1;
    @(negedge i_clk);
    bif.bus_we    = 1'b0;
    bif.dl_ready  = 1'b0;
    rd(A_STAT, 32'h9000_000F, "stat_full_pushpop");
    chk("dl_head_after_pop", bif.dl_data, 32'h101);
    wr(A_CTRL, 32'h3);
    rd(A_STAT, 32'h1000_0000, "stat_flush_clr");
    chk("dl_flushed", 32'(bif.dl_valid), 32'd0);

    // uplink underflow
    rd(A_DATA, 32'd0, "ul_unf_data");
    @(negedge i_clk);
    chk("ack_one_pulse", 32'(bif.bus_ack), 32'd0);
    rd(A_STAT, 32'h5000_0000, "stat_unf");
    wr(A_CTRL, 32'h1);
    rd(A_STAT, 32'h1000_0000, "stat_unf_clr");

    // decode: unmapped address ignored, CTRL reads as zero
    @(negedge i_clk);
    bif.bus_addr = A_BAD;
    bif.bus_re   = 1'b1;
    @(negedge i_clk);
    bif.bus_re   = 1'b0;
    chk("bad_addr_no_ack", 32'(bif.bus_ack), 32'd0);
    wr(A_BAD, 32'h1234);
    chk("bad_addr_no_push", 32'(bif.dl_valid), 32'd0);
    rd(A_CTRL, 32'd0, "ctrl_read");

    // uplink push and same-cycle host read
    @(negedge i_clk);
    bif.ul_valid = 1'b1;
    bif.ul_data  = 32'h11;
    @(negedge i_clk);
    bif.ul_data  = 32'h22;
    bif.bus_addr = A_DATA;
    bif.bus_re   = 1'b1;
    @(negedge i_clk);
    bif.ul_valid = 1'b0;
    bif.bus_re   = 1'b0;
    chk("ul_first_ack", 32'(bif.bus_ack), 32'd1);
    chk("ul_first", bif.bus_rdata, 32'h11);
    rd(A_DATA, 32'h22, "ul_second");
    rd(A_STAT, 32'h1000_0000, "stat_ul_drained");

    // fill uplink
    for (int i = 0; i < 16; i++) begin
      @(negedge i_clk);
      bif.ul_valid = 1'b1;
      bif.ul_data  = 32'h200 + 32'(i);
    end
    @(negedge i_clk);
    bif.ul_valid = 1'b0;
    chk("ul_full_not_ready", 32'(bif.ul_ready), 32'd0);
    rd(A_STAT, 32'h0010_0000, "stat_ul16");
    rd(A_DATA, 32'h200, "ul_head");
    chk("ul_ready_again", 32'(bif.ul_ready), 32'd1);
    wr(A_DATA, 32'h66);
    wr(A_DATA, 32'h67);
    rd(A_STAT, 32'h000F_0002, "stat_both");
    wr(A_CTRL, 32'h2);
    rd(A_STAT, 32'h1000_0000, "stat_flushed");
    chk("flush_dl_valid", 32'(bif.dl_valid), 32'd0);

    // flush wins over same-cycle uplink handshake
    @(negedge i_clk);
    bif.ul_valid  = 1'b1;
    bif.ul_data   = 32'h77;
    bif.bus_addr  = A_CTRL;
    bif.bus_wdata = 32'h2;
    bif.bus_we    = 1'b1;
    @(negedge i_clk);
    bif.ul_valid  = 1'b0;
    bif.bus_we    = 1'b0;
    rd(A_STAT, 32'h1000_0000, "stat_flush_hs");

    // async reset while a read ack is pending
    wr(A_DATA, 32'h66);
    @(negedge i_clk);
    bif.bus_addr = A_STAT;
    bif.bus_re   = 1'b1;
    @(posedge i_clk);
    #1;
    chk("ack_pending", 32'(bif.bus_ack), 32'd1);
    #1;
    i_rstn = 1'b0;
    #1;
    chk("rst_kills_ack", 32'(bif.bus_ack), 32'd0);
    chk("rst_dl_empty", 32'(bif.dl_valid), 32'd0);
    @(negedge i_clk);
    bif.bus_re = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      chk("no_ack_after_rst", 32'(bif.bus_ack), 32'd0);
    end
    rd(A_STAT, 32'h1000_0000, "stat_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
